// File: rtl/counter_ring_prog.sv
// Programmable ring/Johnson counter with runtime mode, direction, active length, load, wrap pulse and step count.
// Optional sticky state-validity flag on o_err when COUNTER_RING_ERR_CHECK_EN is defined.
module counter_ring_prog #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] RESET_PATTERN = WIDTH'(1),
    localparam int LW = $clog2(WIDTH) + 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_mode,
    input  logic             i_dir,
    input  logic [LW-1:0]    i_len,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_ring_out,
    output logic             o_wrap,
    output logic [LW:0]      o_step,
    output logic             o_err
);

    logic [WIDTH-1:0] ring_q, ring_d;
    logic             wrap_q, wrap_d;
    logic [LW:0]      step_q, step_d;
    logic             mode_q, dir_q;
    logic [LW-1:0]    len_q;

    logic [LW-1:0]    le;
    logic [WIDTH-1:0] mask, q_win, rot, stepped;
    logic             top_bit, wrap_bit, cfg_chg;
    logic [LW:0]      period, step_inc;

    always_comb begin
        if (i_len < LW'(2)) begin
            le = LW'(2);
        end else if (i_len > LW'(WIDTH)) begin
            le = LW'(WIDTH);
        end else begin
            le = i_len;
        end
    end

    // Window of le bits; shifting by WIDTH yields zero so the full-width mask is all ones.
    assign mask     = ~({WIDTH{1'b1}} << le);
    assign q_win    = ring_q & mask;
    assign top_bit  = |(q_win & (WIDTH'(1) << (le - LW'(1))));
    assign wrap_bit = (i_dir ? top_bit : q_win[0]) ^ i_mode;

    always_comb begin
        if (i_dir) begin
            rot = ((q_win << 1) & mask) | WIDTH'(wrap_bit);
        end else begin
            rot = (q_win >> 1) | (WIDTH'(wrap_bit) << (le - LW'(1)));
        end
    end

    // A ring that lost its token restarts from bit 0; all-zero is a legal Johnson state.
    assign stepped  = (!i_mode && (rot == '0)) ? WIDTH'(1) : rot;
    assign period   = i_mode ? {le, 1'b0} : {1'b0, le};
    assign step_inc = step_q + (LW+1)'(1);
    assign cfg_chg  = (i_mode != mode_q) || (i_dir != dir_q) || (le != len_q);

    always_comb begin
        ring_d = ring_q;
        step_d = step_q;
        wrap_d = 1'b0;
        if (i_load) begin
            ring_d = i_load_val & mask;
            step_d = '0;
        end else begin
            if (i_enable) begin
                ring_d = stepped;
            end
            if (cfg_chg) begin
                step_d = '0;
            end else if (i_enable) begin
                if (step_inc == period) begin
                    step_d = '0;
                    wrap_d = 1'b1;
                end else begin
                    step_d = step_inc;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ring_q <= RESET_PATTERN;
            wrap_q <= 1'b0;
            step_q <= '0;
            mode_q <= 1'b0;
            dir_q  <= 1'b0;
            len_q  <= LW'(WIDTH);
        end else begin
            ring_q <= ring_d;
            wrap_q <= wrap_d;
            step_q <= step_d;
            mode_q <= i_mode;
            dir_q  <= i_dir;
            len_q  <= le;
        end
    end

    assign o_ring_out = ring_q;
    assign o_wrap     = wrap_q;
    assign o_step     = step_q;

`ifdef COUNTER_RING_ERR_CHECK_EN
    logic err_q, err_d;

    // v is already windowed; Johnson accepts 0..01..1 and 1..10..0 within the window.
    function automatic logic win_valid(input logic [WIDTH-1:0] v, input logic johnson,
                                       input logic [WIDTH-1:0] m);
        logic [WIDTH-1:0] inv;
        logic             ok;
        inv = ~v & m;
        if (johnson) begin
            ok = ((v & (v + WIDTH'(1))) == '0) || ((inv & (inv + WIDTH'(1))) == '0);
        end else begin
            ok = (v != '0) && ((v & (v - WIDTH'(1))) == '0);
        end
        return ok;
    endfunction

    always_comb begin
        if (i_load) begin
            err_d = !win_valid(i_load_val & mask, i_mode, mask);
        end else begin
            err_d = err_q | !win_valid(q_win, i_mode, mask);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_counter_ring_prog.sv
// Bench for counter_ring_prog: directed steps plus randomized traffic against a bit-array reference model.
module tb_counter_ring_prog;

    localparam int W  = 8;
    localparam int LW = $clog2(W) + 2;
`ifdef COUNTER_RING_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          i_clk;
    logic          i_rst_n;
    logic          i_enable;
    logic          i_mode;
    logic          i_dir;
    logic [LW-1:0] i_len;
    logic          i_load;
    logic [W-1:0]  i_load_val;
    logic [W-1:0]  o_ring_out;
    logic          o_wrap;
    logic [LW:0]   o_step;
    logic          o_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [W-1:0] m_state;
    int           m_step;
    bit           m_wrap;
    bit           m_err;
    bit           m_mode, m_dir;
    int           m_le;

    counter_ring_prog #(.WIDTH(W)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_enable   (i_enable),
        .i_mode     (i_mode),
        .i_dir      (i_dir),
        .i_len      (i_len),
        .i_load     (i_load),
        .i_load_val (i_load_val),
        .o_ring_out (o_ring_out),
        .o_wrap     (o_wrap),
        .o_step     (o_step),
        .o_err      (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ring"}, 64'(o_ring_out), 64'(m_state));
        check({tag, ".wrap"}, 64'(o_wrap), 64'(m_wrap));
        check({tag, ".step"}, 64'(o_step), 64'(m_step));
        check({tag, ".err"}, 64'(o_err), 64'(m_err));
    endtask

    function automatic int clamp_len(input int len);
        if (len < 2) return 2;
        if (len > W) return W;
        return len;
    endfunction

    // Rotation of the le-bit window as an index permutation over a bit array.
    function automatic logic [W-1:0] m_rotate(input logic [W-1:0] q, input int le,
                                              input bit johnson, input bit left);
        bit           b[W];
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) b[i] = (i < le) ? q[i] : 1'b0;
        for (int i = 0; i < le; i++) begin
            if (!left) r[i] = b[(i + 1) % le] ^ (johnson && (i == le - 1));
            else       r[i] = b[(i + le - 1) % le] ^ (johnson && (i == 0));
        end
        if (!johnson && (r == '0)) r[0] = 1'b1;
        return r;
    endfunction

    function automatic bit m_valid(input logic [W-1:0] q, input int le, input bit johnson);
        int ones, edges;
        ones  = 0;
        edges = 0;
        for (int i = 0; i < le; i++) begin
            if (q[i]) ones++;
            if (i > 0 && q[i] != q[i-1]) edges++;
        end
        return johnson ? (edges <= 1) : (ones == 1);
    endfunction

    task automatic model_reset();
        m_state = W'(1);
        m_step  = 0;
        m_wrap  = 0;
        m_err   = 0;
        m_mode  = 0;
        m_dir   = 0;
        m_le    = W;
    endtask

    task automatic model_step(input bit en, input bit ld, input logic [W-1:0] lv,
                              input bit md, input bit dr, input int len);
        int le, p;
        bit chg;
        logic [W-1:0] lw;
        le  = clamp_len(len);
        p   = md ? 2 * le : le;
        chg = (md != m_mode) || (dr != m_dir) || (le != m_le);
        lw  = lv;
        for (int i = 0; i < W; i++) if (i >= le) lw[i] = 1'b0;
        if (ERR_EN) begin
            if (ld) m_err = !m_valid(lw, le, md);
            else if (!m_valid(m_state, le, md)) m_err = 1;
        end
        m_wrap = 0;
        if (ld) begin
            m_state = lw;
            m_step  = 0;
        end else begin
            if (en) m_state = m_rotate(m_state, le, md, dr);
            if (chg) m_step = 0;
            else if (en) begin
                m_step++;
                if (m_step == p) begin
                    m_step = 0;
                    m_wrap = 1;
                end
            end
        end
        m_mode = md;
        m_dir  = dr;
        m_le   = le;
    endtask

    task automatic cycle(input string tag, input bit en, input bit ld, input logic [W-1:0] lv,
                         input bit md, input bit dr, input int len);
        i_enable   = en;
        i_load     = ld;
        i_load_val = lv;
        i_mode     = md;
        i_dir      = dr;
        i_len      = LW'(len);
        @(posedge i_clk);
        model_step(en, ld, lv, md, dr, len);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        i_enable   = 0;
        i_load     = 0;
        i_load_val = '0;
        i_mode     = 0;
        i_dir      = 0;
        i_len      = LW'(W);
    endtask

    initial begin
        bit md, dr, en, ld;
        int len;

        // Power-on reset
        i_rst_n = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        check_all("reset");
        @(negedge i_clk);
        i_rst_n = 1;

        // Ring right, full length
        for (int i = 0; i < 8; i++) cycle("ring_r8", 1, 0, '0, 0, 0, 8);
        check("ring_r8_final_val", 64'(o_ring_out), 64'h01);
        check("ring_r8_final_wrap", 64'(o_wrap), 64'h1);

        // Johnson right, length 4
        cycle("joh_load", 0, 1, 8'h00, 1, 0, 4);
        for (int i = 0; i < 8; i++) cycle("joh_r4", 1, 0, '0, 1, 0, 4);
        check("joh_r4_final_val", 64'(o_ring_out), 64'h00);
        check("joh_r4_final_wrap", 64'(o_wrap), 64'h1);

        // Ring left, length 3, then length 1 clamped to 2
        cycle("ringl3_load", 0, 1, 8'h01, 0, 1, 3);
        for (int i = 0; i < 3; i++) cycle("ring_l3", 1, 0, '0, 0, 1, 3);
        check("ring_l3_final_val", 64'(o_ring_out), 64'h01);
        check("ring_l3_final_wrap", 64'(o_wrap), 64'h1);
        cycle("ringl1_load", 0, 1, 8'h01, 0, 1, 1);
        cycle("ring_l1_a", 1, 0, '0, 0, 1, 1);
        check("ring_l1_a_val", 64'(o_ring_out), 64'h02);
        cycle("ring_l1_b", 1, 0, '0, 0, 1, 1);
        check("ring_l1_b_val", 64'(o_ring_out), 64'h01);
        check("ring_l1_b_wrap", 64'(o_wrap), 64'h1);

        // Load wins over enable
        cycle("load_en", 1, 1, 8'h10, 0, 0, 8);
        check("load_en_val", 64'(o_ring_out), 64'h10);
        check("load_en_step", 64'(o_step), 64'h0);
        for (int i = 0; i < 3; i++) cycle("post_load", 1, 0, '0, 0, 0, 8);

        // Asynchronous reset mid-cycle
        #3;
        i_rst_n = 0;
        idle_inputs();
        model_reset();
        #1;
        check_all("async_rst");
        check("async_rst_val", 64'(o_ring_out), 64'h01);
        @(negedge i_clk);
        i_rst_n = 1;

        // Token recovery on length shrink
        cycle("tok_load", 0, 1, 8'h40, 0, 0, 8);
        cycle("tok_shrink", 1, 0, '0, 0, 0, 4);
        check("tok_val", 64'(o_ring_out), 64'h01);
        check("tok_step", 64'(o_step), 64'h0);
        check("tok_wrap", 64'(o_wrap), 64'h0);

        // State-validity flag
        cycle("err_load03", 0, 1, 8'h03, 0, 0, 8);
        check("err_load03_flag", 64'(o_err), 64'(ERR_EN));
        for (int i = 0; i < 5; i++) begin
            cycle("err_sticky", 1, 0, '0, 0, 0, 8);
            check("err_sticky_flag", 64'(o_err), 64'(ERR_EN));
        end
        cycle("err_load01", 0, 1, 8'h01, 0, 0, 8);
        check("err_load01_flag", 64'(o_err), 64'h0);
        cycle("err_joh05", 0, 1, 8'h05, 1, 0, 4);
        check("err_joh05_flag", 64'(o_err), 64'(ERR_EN));

        // Randomized traffic
        md  = 0;
        dr  = 0;
        len = W;
        cycle("rnd_init", 0, 1, 8'h01, md, dr, len);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 29) == 0) md = ~md;
            if ($urandom_range(0, 29) == 0) dr = ~dr;
            if ($urandom_range(0, 24) == 0) len = $urandom_range(0, (1 << LW) - 1);
            en = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 39) == 0);
            cycle("rnd", en, ld, W'($urandom), md, dr, len);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
